// File: rtl/systolic_sched_if.sv
// Transfer handshake between the tile scheduler and the AXI transfer engine.
interface systolic_sched_if;
  logic       req_valid;
  logic [3:0] req_sel;
  logic       req_ready;
  logic       xfer_done;

  modport master (
    output req_valid,
    output req_sel,
    input  req_ready,
    input  xfer_done
  );

  modport slave (
    input  req_valid,
    input  req_sel,
    output req_ready,
    output xfer_done
  );
endinterface

// File: rtl/systolic_sched.sv
// Tile scheduler for the LxL systolic array: sequences C/A/B loads, the
// systolic and accumulate phases over k_tiles K-tiles, then the D write-back.
module systolic_sched #(
  parameter int unsigned L       = 8,
  parameter int unsigned ACC_LAT = 4,
  parameter int unsigned KW      = 8,
  parameter int unsigned CW      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KW-1:0]     k_tiles,
  systolic_sched_if.master  xfer,
  input  logic              pe_stall,
  output logic              array_en,
  output logic              acc_en,
  output logic              array_clr,
  output logic              busy,
  output logic              done,
  output logic [KW-1:0]     tile_idx
);

  localparam logic [CW-1:0] SYS_CYC = CW'(3 * L - 2);
  localparam logic [CW-1:0] ACC_CYC = CW'(ACC_LAT);

  typedef enum logic [2:0] {
    IDLE, READ_C, LOAD_A, LOAD_B, SYSTOLIC, ACCUM, WRITE_D, FINISH
  } state_t;

  state_t        state_q, state_d;
  logic          req_valid_q, req_valid_d;
  logic          clr_q, clr_d;
  logic [KW-1:0] tile_q, tile_d;
  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] sys_q, sys_d;
  logic [CW-1:0] acc_q, acc_d;
  logic [KW:0]   tile_next;
  logic          xfer_state_d;

  // Widened by one bit so k_tiles = 2^KW-1 terminates without wrapping.
  assign tile_next = {1'b0, tile_q} + (KW+1)'(1);

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      clr_q       <= 1'b0;
      tile_q      <= '0;
      k_q         <= '0;
      sys_q       <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      clr_q       <= clr_d;
      tile_q      <= tile_d;
      k_q         <= k_d;
      sys_q       <= sys_d;
      acc_q       <= acc_d;
    end
  end

  // Next-state, counter and request-flag logic.
  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q & ~xfer.req_ready;
    clr_d       = 1'b0;
    tile_d      = tile_q;
    k_d         = k_q;
    sys_d       = sys_q;
    acc_d       = acc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (k_tiles != '0) begin
            k_d     = k_tiles;
            tile_d  = '0;
            state_d = READ_C;
          end else begin
            state_d = FINISH;
          end
        end
      end
      READ_C:  if (!req_valid_q && xfer.xfer_done) state_d = LOAD_A;
      LOAD_A:  if (!req_valid_q && xfer.xfer_done) state_d = LOAD_B;
      LOAD_B: begin
        if (!req_valid_q && xfer.xfer_done) begin
          state_d = SYSTOLIC;
          clr_d   = 1'b1;
          sys_d   = SYS_CYC;
        end
      end
      SYSTOLIC: begin
        if (!pe_stall) begin
          sys_d = sys_q - CW'(1);
          if (sys_q == CW'(1)) begin
            state_d = ACCUM;
            acc_d   = ACC_CYC;
          end
        end
      end
      ACCUM: begin
        if (!pe_stall) begin
          acc_d = acc_q - CW'(1);
          if (acc_q == CW'(1)) begin
            if (tile_next < {1'b0, k_q}) begin
              tile_d  = tile_next[KW-1:0];
              state_d = LOAD_A;
            end else begin
              state_d = WRITE_D;
            end
          end
        end
      end
      WRITE_D: if (!req_valid_q && xfer.xfer_done) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Raise the request on entry to any transfer state; the flag then
    // self-clears on the first accepted cycle.
    xfer_state_d = (state_d == READ_C) || (state_d == LOAD_A) ||
                   (state_d == LOAD_B) || (state_d == WRITE_D);
    if (xfer_state_d && (state_d != state_q)) req_valid_d = 1'b1;
  end

  // Output decode from registered state (pe_stall gates the flow enables).
  always_comb begin
    xfer.req_sel = 4'b0000;
    if (req_valid_q) begin
      case (state_q)
        READ_C:  xfer.req_sel = 4'b0001;
        LOAD_A:  xfer.req_sel = 4'b0010;
        LOAD_B:  xfer.req_sel = 4'b0100;
        WRITE_D: xfer.req_sel = 4'b1000;
        default: xfer.req_sel = 4'b0000;
      endcase
    end
    xfer.req_valid = req_valid_q;
    array_en       = (state_q == SYSTOLIC) && !pe_stall;
    acc_en         = (state_q == ACCUM) && !pe_stall;
    array_clr      = clr_q;
    busy           = (state_q != IDLE);
    done           = (state_q == FINISH);
    tile_idx       = tile_q;
  end

endmodule
